// File: rtl/disp_scan4.sv
// Four-digit multiplexed hex display scanner with per-digit guard time,
// double-buffered display data and optional leading-zero blanking.
module disp_scan4 #(
    parameter int CLK_DIV  = 50000,
    parameter int DEAD_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] data_in,
    input  logic        lz_blank,
    output logic [3:0]  hexin,
    output logic [3:0]  dig_en_n,
    output logic        pending,
    output logic        frame_tick,
    output logic        o_dbg_state
);

    typedef enum logic {
        ST_DEAD = 1'b0,
        ST_ON   = 1'b1
    } state_t;

    localparam int                CNT_W     = 20;
    localparam logic [CNT_W-1:0]  ON_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  DEAD_LAST = (DEAD_CYC > 0) ? CNT_W'(DEAD_CYC - 1) : '0;
    localparam bit                NO_GUARD  = (DEAD_CYC == 0);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_idx;
    logic [15:0]        r_disp;
    logic [15:0]        r_shadow;
    logic               r_pending;
    logic [3:0]         r_hexin;
    logic [3:0]         r_dig_en_n;
    logic               r_frame_tick;

    state_t             w_state_next;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [1:0]         w_idx_next;
    logic [15:0]        w_disp_next;
    logic [15:0]        w_shadow_next;
    logic               w_pending_next;
    logic               w_on_done;
    logic               w_dead_done;
    logic               w_wrap;
    logic               w_enter_on;
    logic               w_blank;
    logic [3:0]         w_dig_next;

    // load is a one-cycle strobe with no back-pressure: every cycle it is high
    // the shadow takes data_in, so the last write before a frame wrap wins.
    always_comb begin
        w_on_done    = (r_state == ST_ON) && (r_cnt == ON_LAST);
        w_dead_done  = (r_state == ST_DEAD) && (NO_GUARD || (r_cnt == DEAD_LAST));
        w_wrap       = w_on_done && (r_idx == 2'd3);

        w_state_next = r_state;
        w_cnt_next   = r_cnt + CNT_W'(1);
        w_idx_next   = r_idx;
        w_enter_on   = 1'b0;
        if (w_on_done) begin
            w_cnt_next   = '0;
            w_idx_next   = r_idx + 2'd1;
            w_state_next = NO_GUARD ? ST_ON : ST_DEAD;
            w_enter_on   = NO_GUARD;
        end else if (w_dead_done) begin
            w_cnt_next   = '0;
            w_state_next = ST_ON;
            w_enter_on   = 1'b1;
        end

        w_disp_next    = (w_wrap && r_pending) ? r_shadow : r_disp;
        w_shadow_next  = load ? data_in : r_shadow;
        w_pending_next = load | (r_pending & ~w_wrap);

        // Blanking is judged against the value that will be on display next cycle.
        case (w_idx_next)
            2'd1:    w_blank = lz_blank && (w_disp_next[15:4] == 12'h000);
            2'd2:    w_blank = lz_blank && (w_disp_next[15:8] == 8'h00);
            2'd3:    w_blank = lz_blank && (w_disp_next[15:12] == 4'h0);
            default: w_blank = 1'b0;
        endcase

        // The enable pattern is fixed at the start of each ON phase and held.
        if (w_state_next != ST_ON) begin
            w_dig_next = 4'b1111;
        end else if (w_enter_on) begin
            w_dig_next = w_blank ? 4'b1111 : ~(4'b0001 << w_idx_next);
        end else begin
            w_dig_next = r_dig_en_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_DEAD;
            r_cnt        <= '0;
            r_idx        <= 2'd0;
            r_disp       <= 16'h0000;
            r_shadow     <= 16'h0000;
            r_pending    <= 1'b0;
            r_hexin      <= 4'h0;
            r_dig_en_n   <= 4'b1111;
            r_frame_tick <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_idx        <= w_idx_next;
            r_disp       <= w_disp_next;
            r_shadow     <= w_shadow_next;
            r_pending    <= w_pending_next;
            r_hexin      <= w_disp_next[{w_idx_next, 2'b00} +: 4];
            r_dig_en_n   <= w_dig_next;
            r_frame_tick <= w_wrap;
        end
    end

    assign hexin       = r_hexin;
    assign dig_en_n    = r_dig_en_n;
    assign pending     = r_pending;
    assign frame_tick  = r_frame_tick;
    assign o_dbg_state = (r_state == ST_ON);

endmodule

// File: tb/tb_disp_scan4.sv
// Directed bench for disp_scan4: a guarded instance (CLK_DIV=4, DEAD_CYC=1)
// driven from a cycle table, and a no-guard instance (DEAD_CYC=0).
module tb_disp_scan4;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] data_in;
    logic        lz_blank;

    logic [3:0]  hex_a, en_a, hex_b, en_b;
    logic        pend_a, tick_a, dbg_a, pend_b, tick_b, dbg_b;

    int n_checks = 0;
    int n_errors = 0;

    disp_scan4 #(.CLK_DIV(4), .DEAD_CYC(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in), .lz_blank(lz_blank),
        .hexin(hex_a), .dig_en_n(en_a), .pending(pend_a), .frame_tick(tick_a),
        .o_dbg_state(dbg_a)
    );

    disp_scan4 #(.CLK_DIV(4), .DEAD_CYC(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in), .lz_blank(lz_blank),
        .hexin(hex_b), .dig_en_n(en_b), .pending(pend_b), .frame_tick(tick_b),
        .o_dbg_state(dbg_b)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // vector table
    typedef struct {
        logic        ld;
        logic [15:0] d;
        logic        lz;
        logic [3:0]  hx;
        logic [3:0]  en;
        logic        tk;
        logic        pd;
    } vec_t;

    vec_t vecs[$];
    logic t_lz;

    task automatic add(input int n, input logic ld, input logic [15:0] d,
                       input logic [3:0] hx, input logic [3:0] en,
                       input logic tk, input logic pd);
        vec_t v;
        v.ld = ld; v.d = d; v.lz = t_lz; v.hx = hx; v.en = en; v.tk = tk; v.pd = pd;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    // invariant: never more than one digit enabled
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("onehot_a", ($countones(~en_a) > 1) ? 16'd1 : 16'd0, 16'd0);
            chk("onehot_b", ($countones(~en_b) > 1) ? 16'd1 : 16'd0, 16'd0);
        end
    end

    initial begin
        logic [3:0] exp_b;

        rst_n = 1'b1; load = 1'b0; data_in = 16'h0000; lz_blank = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset hexin_a", 16'(hex_a), 16'h0);
        chk("reset en_a",    16'(en_a),  16'hF);
        chk("reset pend_a",  16'(pend_a), 16'h0);
        chk("reset tick_a",  16'(tick_a), 16'h0);
        chk("reset dbg_a",   16'(dbg_a),  16'h0);
        chk("reset en_b",    16'(en_b),  16'hF);
        chk("reset dbg_b",   16'(dbg_b),  16'h0);

        // Each row: inputs for the next rising edge, outputs expected after it.
        t_lz = 1'b0;
        // frame 1: blank display, 1234 waiting in the shadow
        add(1, 1, 16'h1234, 4'h0, 4'hE, 0, 1);
        add(3, 0, 16'h0,    4'h0, 4'hE, 0, 1);
        add(1, 0, 16'h0, 4'h0, 4'hF, 0, 1);  add(4, 0, 16'h0, 4'h0, 4'hD, 0, 1);
        add(1, 0, 16'h0, 4'h0, 4'hF, 0, 1);  add(4, 0, 16'h0, 4'h0, 4'hB, 0, 1);
        add(1, 0, 16'h0, 4'h0, 4'hF, 0, 1);  add(4, 0, 16'h0, 4'h0, 4'h7, 0, 1);
        add(1, 0, 16'h0, 4'h4, 4'hF, 1, 0);
        // frame 2: scan order of 1234
        add(4, 0, 16'h0, 4'h4, 4'hE, 0, 0);
        add(1, 0, 16'h0, 4'h3, 4'hF, 0, 0);  add(4, 0, 16'h0, 4'h3, 4'hD, 0, 0);
        add(1, 0, 16'h0, 4'h2, 4'hF, 0, 0);  add(4, 0, 16'h0, 4'h2, 4'hB, 0, 0);
        add(1, 0, 16'h0, 4'h1, 4'hF, 0, 0);  add(4, 0, 16'h0, 4'h1, 4'h7, 0, 0);
        add(1, 0, 16'h0, 4'h4, 4'hF, 1, 0);
        // frame 3: ABCD loaded mid-frame, display holds 1234 until the wrap
        add(4, 0, 16'h0,    4'h4, 4'hE, 0, 0);
        add(1, 1, 16'hABCD, 4'h3, 4'hF, 0, 1);  add(4, 0, 16'h0, 4'h3, 4'hD, 0, 1);
        add(1, 0, 16'h0, 4'h2, 4'hF, 0, 1);     add(4, 0, 16'h0, 4'h2, 4'hB, 0, 1);
        add(1, 0, 16'h0, 4'h1, 4'hF, 0, 1);     add(4, 0, 16'h0, 4'h1, 4'h7, 0, 1);
        add(1, 0, 16'h0, 4'hD, 4'hF, 1, 0);
        // frame 4: ABCD shown; 1111 loaded, then 2222 on the wrap edge itself
        add(4, 0, 16'h0, 4'hD, 4'hE, 0, 0);
        add(1, 0, 16'h0, 4'hC, 4'hF, 0, 0);     add(4, 0, 16'h0, 4'hC, 4'hD, 0, 0);
        add(1, 1, 16'h1111, 4'hB, 4'hF, 0, 1);  add(4, 0, 16'h0, 4'hB, 4'hB, 0, 1);
        add(1, 0, 16'h0, 4'hA, 4'hF, 0, 1);     add(4, 0, 16'h0, 4'hA, 4'h7, 0, 1);
        add(1, 1, 16'h2222, 4'h1, 4'hF, 1, 1);
        // frame 5: 1111 shown with 2222 still pending
        add(4, 0, 16'h0, 4'h1, 4'hE, 0, 1);
        add(1, 0, 16'h0, 4'h1, 4'hF, 0, 1);  add(4, 0, 16'h0, 4'h1, 4'hD, 0, 1);
        add(1, 0, 16'h0, 4'h1, 4'hF, 0, 1);  add(4, 0, 16'h0, 4'h1, 4'hB, 0, 1);
        add(1, 0, 16'h0, 4'h1, 4'hF, 0, 1);  add(4, 0, 16'h0, 4'h1, 4'h7, 0, 1);
        add(1, 0, 16'h0, 4'h2, 4'hF, 1, 0);
        // frame 6: 2222 shown, blanking enabled, 0050 loaded
        add(4, 0, 16'h0, 4'h2, 4'hE, 0, 0);
        t_lz = 1'b1;
        add(1, 1, 16'h0050, 4'h2, 4'hF, 0, 1);  add(4, 0, 16'h0, 4'h2, 4'hD, 0, 1);
        add(1, 0, 16'h0, 4'h2, 4'hF, 0, 1);     add(4, 0, 16'h0, 4'h2, 4'hB, 0, 1);
        add(1, 0, 16'h0, 4'h2, 4'hF, 0, 1);     add(4, 0, 16'h0, 4'h2, 4'h7, 0, 1);
        add(1, 0, 16'h0, 4'h0, 4'hF, 1, 0);
        // frame 7: 0050 with digits 3 and 2 blanked; 0000 loaded
        add(4, 0, 16'h0, 4'h0, 4'hE, 0, 0);
        add(1, 1, 16'h0000, 4'h5, 4'hF, 0, 1);  add(4, 0, 16'h0, 4'h5, 4'hD, 0, 1);
        add(1, 0, 16'h0, 4'h0, 4'hF, 0, 1);     add(4, 0, 16'h0, 4'h0, 4'hF, 0, 1);
        add(1, 0, 16'h0, 4'h0, 4'hF, 0, 1);     add(4, 0, 16'h0, 4'h0, 4'hF, 0, 1);
        add(1, 0, 16'h0, 4'h0, 4'hF, 1, 0);
        // frame 8: 0000 shows only digit 0; 9876 loaded
        add(4, 0, 16'h0, 4'h0, 4'hE, 0, 0);
        add(1, 1, 16'h9876, 4'h0, 4'hF, 0, 1);  add(4, 0, 16'h0, 4'h0, 4'hF, 0, 1);
        add(1, 0, 16'h0, 4'h0, 4'hF, 0, 1);     add(4, 0, 16'h0, 4'h0, 4'hF, 0, 1);
        add(1, 0, 16'h0, 4'h0, 4'hF, 0, 1);     add(4, 0, 16'h0, 4'h0, 4'hF, 0, 1);
        add(1, 0, 16'h0, 4'h6, 4'hF, 1, 0);

        // driver: apply the table
        rst_n = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            load     = vecs[i].ld;
            data_in  = vecs[i].d;
            lz_blank = vecs[i].lz;
            @(negedge clk);
            chk($sformatf("row%0d hexin", i + 1),      16'(hex_a),  16'(vecs[i].hx));
            chk($sformatf("row%0d dig_en_n", i + 1),   16'(en_a),   16'(vecs[i].en));
            chk($sformatf("row%0d frame_tick", i + 1), 16'(tick_a), 16'(vecs[i].tk));
            chk($sformatf("row%0d pending", i + 1),    16'(pend_a), 16'(vecs[i].pd));
        end

        // asynchronous reset during digit 2 with a load pending
        lz_blank = 1'b0;
        load = 1'b1; data_in = 16'h5555;
        @(negedge clk);
        load = 1'b0; data_in = 16'h0000;
        chk("pre_rst pending", 16'(pend_a), 16'h1);
        repeat (11) @(negedge clk);
        chk("pre_rst hexin",    16'(hex_a), 16'h8);
        chk("pre_rst dig_en_n", 16'(en_a),  16'hB);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst dig_en_n",   16'(en_a),   16'hF);
        chk("async_rst hexin",      16'(hex_a),  16'h0);
        chk("async_rst pending",    16'(pend_a), 16'h0);
        chk("async_rst frame_tick", 16'(tick_a), 16'h0);
        chk("async_rst en_b",       16'(en_b),   16'hF);
        @(negedge clk);
        chk("held_rst dig_en_n", 16'(en_a), 16'hF);
        rst_n = 1'b1;

        // after release: guarded instance restarts, no-guard instance scans back-to-back
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("release dig_en_n", 16'(en_a),   16'hE);
                chk("release hexin",    16'(hex_a),  16'h0);
                chk("release pending",  16'(pend_a), 16'h0);
                chk("release dbg_a",    16'(dbg_a),  16'h1);
            end
            if (k == 5) chk("release guard dig_en_n", 16'(en_a), 16'hF);
            if (k == 20) begin
                chk("discard frame_tick", 16'(tick_a), 16'h1);
                chk("discard hexin",      16'(hex_a),  16'h0);
                chk("discard pending",    16'(pend_a), 16'h0);
            end
            exp_b = ~(4'b0001 << (((k - 1) / 4) % 4));
            chk($sformatf("noguard k%0d dig_en_n", k),   16'(en_b),   16'(exp_b));
            chk($sformatf("noguard k%0d frame_tick", k), 16'(tick_b),
                (k == 17 || k == 33) ? 16'h1 : 16'h0);
        end

        // final report
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/disp_scan4.md
DISP_SCAN4 -- requirements
Module: disp_scan4

Parameters
REQ-001 The block SHALL have parameter CLK_DIV, default 50000: number of clocks each digit is lit; legal range 2..2^20.
REQ-002 The block SHALL have parameter DEAD_CYC, default 16: all-off guard clocks between digits; legal range 0..255, where 0 means no guard phase.

Interface
REQ-003 The block SHALL have port clk, input, 1 bit: single system clock; all logic on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port load, input, 1 bit: capture data_in into the shadow register this cycle.
REQ-006 The block SHALL have port data_in, input, 16 bits: four hex nibbles, where [3:0] is digit 0 (least significant) and [15:12] is digit 3.
REQ-007 The block SHALL have port lz_blank, input, 1 bit: leading-zero blanking enable.
REQ-008 The block SHALL have port hexin, output, 4 bits: nibble of the currently selected digit, which feeds the hex-to-7-segment decoder.
REQ-009 The block SHALL have port dig_en_n, output, 4 bits: active-low digit enables, one-hot-low when a digit is lit.
REQ-010 The block SHALL have port pending, output, 1 bit: the shadow holds data not yet displayed.
REQ-011 The block SHALL have port frame_tick, output, 1 bit: single-cycle pulse on digit-index wrap from 3 to 0.

Function
REQ-012 The state machine SHALL have two states, ON and DEAD, plus a 2-bit digit index idx, a prescaler cnt, a 16-bit display register disp_reg and a 16-bit shadow register.
REQ-013 In ON, cnt SHALL increment every clock; when cnt = CLK_DIV-1, cnt SHALL clear, idx SHALL advance (3 wraps to 0), and the state SHALL go to DEAD, or stay in ON with the new idx if DEAD_CYC = 0.
REQ-014 In DEAD, dig_en_n SHALL be 4'b1111 and cnt SHALL count 0..DEAD_CYC-1; after DEAD_CYC clocks the state SHALL go to ON with cnt = 0.
REQ-015 hexin SHALL equal disp_reg[4*idx+3 : 4*idx], registered, and SHALL update on the same edge idx changes, so it is stable throughout DEAD.
REQ-016 In ON, dig_en_n[idx] SHALL be 0 and all other bits 1, unless digit idx is blanked.
REQ-017 Digit i (i = 1..3) SHALL be blanked when lz_blank = 1 and nibbles 3 down to i of disp_reg are all zero; a blanked digit SHALL drive dig_en_n = 4'b1111 for its whole ON phase; digit 0 SHALL never be blanked.
REQ-018 load = 1 SHALL write data_in to the shadow and set pending; repeated loads while pending SHALL overwrite the shadow (last write wins).
REQ-019 On the edge where idx wraps 3 to 0, the block SHALL assert frame_tick for one clock and, if pending = 1, SHALL copy the shadow to disp_reg and clear pending, so the displayed value changes only at frame boundaries (no tearing).
REQ-020 If load coincides with the wrap edge, disp_reg SHALL take the previous shadow, the shadow SHALL take the new data_in, and pending SHALL remain 1.
REQ-021 hexin on the wrap edge SHALL reflect the newly transferred disp_reg nibble 0.
REQ-022 Frame period SHALL be 4*(CLK_DIV+DEAD_CYC) clocks.
REQ-023 dig_en_n SHALL never have more than one bit low in any cycle.

Reset
REQ-024 On rst_n = 0, asynchronously: state = DEAD, cnt = 0, idx = 0, disp_reg = 0, shadow = 0, pending = 0, hexin = 4'h0, dig_en_n = 4'b1111, frame_tick = 0.
REQ-025 After rst_n deasserts, digit 0 SHALL light after DEAD_CYC clocks, or on the first clock if DEAD_CYC = 0.
REQ-026 A reset mid-frame SHALL discard any pending shadow data.

Verification (CLK_DIV = 4, DEAD_CYC = 1 unless stated)
REQ-027 The bench SHALL check scan order: load 16'h1234, wait one frame -> hexin cycles 4, 3, 2, 1 with dig_en_n 1110, 1101, 1011, 0111; each lit for 4 clocks, 1 all-off clock between; frame = 20 clocks.
REQ-028 The bench SHALL check frame-boundary update: load 16'hABCD mid-frame while 16'h1234 is shown -> pending = 1, display unchanged until the wrap edge; at wrap, frame_tick = 1, hexin = D, pending = 0.
REQ-029 The bench SHALL check leading-zero blanking: lz_blank = 1, load 16'h0050 -> digits 3 and 2 show dig_en_n = 1111 during their ON phase; digits 1 and 0 lit (digit 0 shows 0); load 16'h0000 -> only digit 0 lit.
REQ-030 The bench SHALL check load/wrap collision: load 16'h1111 and then 16'h2222 on the exact wrap edge -> disp_reg = 1111, pending stays 1, next wrap shows 2222.
REQ-031 The bench SHALL check the no-guard case: DEAD_CYC = 0 -> no all-off cycles, each digit lit back-to-back, frame = 16 clocks, one-hot-low invariant holds.
REQ-032 The bench SHALL check asynchronous reset: assert rst_n low during the digit 2 ON phase, with a load pending -> dig_en_n = 1111 and hexin = 0 immediately; after release, digit 0 lights after 1 clock showing 0, and pending = 0.
